// File: rtl/shiftreg_burst.sv
// Parametrised shift register with logical/rotate/arithmetic modes, parallel load,
// serial in/out and a counted burst command under a busy/done handshake.
//
// state | meaning
// IDLE  | single-step shifts on i_shift_enable, accepts load and burst start
// RUN   | burst in progress, shifts with latched config until count reaches zero
module shiftreg_burst #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RST_VALUE = 4'b1100,
  parameter int               STEP_W    = 8
) (
  input  logic              clk,
  input  logic              i_ck_rst,
  input  logic              i_shift_enable,
  input  logic              i_shift_dir,
  input  logic [1:0]        i_mode,
  input  logic              i_serial_in,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_data,
  input  logic              i_start,
  input  logic [STEP_W-1:0] i_steps,
  output logic [WIDTH-1:0]  o_shiftreg,
  output logic              o_serial_out,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_LOG  = 2'b00;
  localparam logic [1:0] MODE_ROT  = 2'b01;
  localparam logic [1:0] MODE_ARI  = 2'b10;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  shreg, shreg_nxt;
  logic              serial_out, serial_out_nxt;
  logic              busy, busy_nxt;
  logic              done, done_nxt;
  logic [STEP_W-1:0] remaining, remaining_nxt;
  logic              cfg_dir, cfg_dir_nxt;
  logic [1:0]        cfg_mode, cfg_mode_nxt;

  logic [WIDTH-1:0]  live_reg, burst_reg;
  logic              live_bit, burst_bit;

  // Returns the shifted register; out_bit is the departing bit, or the held
  // serial_out value when the mode does not shift.
  function automatic logic [WIDTH-1:0] shift_fn(
    input  logic [WIDTH-1:0] r,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic             hold_bit,
    output logic             out_bit
  );
    logic [WIDTH-1:0] res;
    res     = r;
    out_bit = hold_bit;
    case (mode)
      MODE_LOG: begin
        out_bit = dir ? r[0] : r[WIDTH-1];
        res     = dir ? {sin, r[WIDTH-1:1]} : {r[WIDTH-2:0], sin};
      end
      MODE_ROT: begin
        out_bit = dir ? r[0] : r[WIDTH-1];
        res     = dir ? {r[0], r[WIDTH-1:1]} : {r[WIDTH-2:0], r[WIDTH-1]};
      end
      MODE_ARI: begin
        out_bit = dir ? r[0] : r[WIDTH-1];
        res     = dir ? {r[WIDTH-1], r[WIDTH-1:1]} : {r[WIDTH-2:0], 1'b0};
      end
      default: begin
        res     = r;
        out_bit = hold_bit;
      end
    endcase
    return res;
  endfunction

  always_comb begin
    live_bit  = serial_out;
    burst_bit = serial_out;
    live_reg  = shift_fn(shreg, i_shift_dir, i_mode, i_serial_in, serial_out, live_bit);
    burst_reg = shift_fn(shreg, cfg_dir, cfg_mode, i_serial_in, serial_out, burst_bit);
  end

  always_ff @(posedge clk or posedge i_ck_rst) begin
    if (i_ck_rst) begin
      state      <= IDLE;
      shreg      <= RST_VALUE;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      remaining  <= '0;
      cfg_dir    <= 1'b0;
      cfg_mode   <= MODE_LOG;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      serial_out <= serial_out_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      remaining  <= remaining_nxt;
      cfg_dir    <= cfg_dir_nxt;
      cfg_mode   <= cfg_mode_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    serial_out_nxt = serial_out;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    remaining_nxt  = remaining;
    cfg_dir_nxt    = cfg_dir;
    cfg_mode_nxt   = cfg_mode;

    case (state)
      IDLE: begin
        if (i_load) begin
          shreg_nxt = i_load_data;
        end else if (i_start) begin
          if (i_steps != '0) begin
            state_nxt     = RUN;
            busy_nxt      = 1'b1;
            remaining_nxt = i_steps;
            cfg_dir_nxt   = i_shift_dir;
            cfg_mode_nxt  = i_mode;
          end else begin
            done_nxt = 1'b1;
          end
        end else if (i_shift_enable) begin
          shreg_nxt      = live_reg;
          serial_out_nxt = live_bit;
        end
      end
      RUN: begin
        if (i_load) begin
          // Load aborts the burst silently: no done pulse.
          shreg_nxt     = i_load_data;
          state_nxt     = IDLE;
          busy_nxt      = 1'b0;
          remaining_nxt = '0;
        end else if (i_shift_enable) begin
          shreg_nxt      = burst_reg;
          serial_out_nxt = burst_bit;
          remaining_nxt  = remaining - 1'b1;
          if (remaining == {{(STEP_W-1){1'b0}}, 1'b1}) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign o_shiftreg   = shreg;
  assign o_serial_out = serial_out;
  assign o_busy       = busy;
  assign o_done       = done;

endmodule

// File: doc/shiftreg_burst.md
Name: shiftreg_burst

Overview:
- Parametrised successor to the 4-bit left/right shift register: generic width, programmable reset pattern, three shift modes, parallel load and serial in/out.
- Adds a burst command that shifts a programmed number of positions under a busy/done handshake.
- Sits between control FSMs and LED/serial output logic.
- Single-step operation is retained for free-running use via i_shift_enable.

Parameters:
- WIDTH, 4, register width in bits (>=2).
- RST_VALUE, 4'b1100, register contents after reset (WIDTH bits).
- STEP_W, 8, width of the burst step count.

Ports:
- clk  in  1  system clock, rising edge.
- i_ck_rst  in  1  reset; asynchronous, active-high.
- i_shift_enable  in  1  shift qualifier; one shift per cycle while high.
- i_shift_dir  in  1  0 = left (toward MSB), 1 = right (toward LSB).
- i_mode  in  2  00 logical, 01 rotate, 10 arithmetic, 11 hold (no shift, counts as a step).
- i_serial_in  in  1  fill bit for logical mode.
- i_load  in  1  parallel load strobe.
- i_load_data  in  WIDTH  parallel load value.
- i_start  in  1  burst start strobe.
- i_steps  in  STEP_W  number of shifts in the burst.
- o_shiftreg  out  WIDTH  register contents.
- o_serial_out  out  1  bit shifted out by the most recent shift.
- o_busy  out  1  burst in progress.
- o_done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (i_ck_rst=1, asynchronous):
  - o_shiftreg=RST_VALUE, o_serial_out=0, o_busy=0, o_done=0, remaining count=0, state IDLE.
  - Takes effect immediately, without waiting for clk.
  - Reset during a burst abandons the burst; no o_done is generated.
- All outputs are registered. Every action has one-cycle latency: visible after the rising edge that samples it.
- Shift rules:
  - Logical left: {r[W-2:0], i_serial_in}. Logical right: {i_serial_in, r[W-1:1]}.
  - Rotate left: {r[W-2:0], r[W-1]}. Rotate right: {r[0], r[W-1:1]}.
  - Arithmetic right: {r[W-1], r[W-1:1]} (sign-preserving). Arithmetic left: {r[W-2:0], 1'b0}.
  - Mode 11: register unchanged.
- o_serial_out:
  - On each shift, takes the departing bit: old r[W-1] for left, old r[0] for right. Rotate reports the rotated bit.
  - Unchanged by load and by mode 11.
  - Held between shifts.
- IDLE, priority per cycle is i_load > i_start > i_shift_enable:
  - i_load: o_shiftreg<=i_load_data; start and enable are ignored that cycle.
  - i_start with i_steps!=0:
    - Latches i_shift_dir, i_mode and i_steps into internal config and goes to RUN; o_busy=1 from the next cycle.
    - No shift occurs on the start edge.
  - i_start with i_steps==0: no shift, stays IDLE, o_done=1 for the next cycle.
  - Otherwise i_shift_enable=1: one shift using the live i_shift_dir/i_mode.
- RUN:
  - Each cycle with i_shift_enable=1 performs one shift using the latched config and decrements the remaining count.
  - i_shift_enable=0 pauses: no shift, count held, o_busy stays 1.
  - The edge performing the last shift returns to IDLE, sets o_busy=0 and o_done=1 for exactly one cycle.
  - i_start in RUN is ignored. Live i_shift_dir/i_mode changes have no effect.
  - i_load in RUN aborts the burst: o_shiftreg<=i_load_data, IDLE, o_busy=0, no o_done.
- i_steps may exceed WIDTH; rotate wraps naturally and logical/arithmetic saturate to fill patterns. Max burst length is 2^STEP_W-1.
- o_done is never asserted with o_busy.

Test Plan:
- Reset: assert i_ck_rst between clock edges -> o_shiftreg=1100 before the next edge; o_busy=0, o_done=0, o_serial_out=0; hold 3 cycles and verify no change.
- Logical left single-step: from 1100, i_serial_in=0, enable 2 cycles -> 1000 then 0000; o_serial_out 1, 1. Repeat right with i_serial_in=1 from 0011 -> 1001, 1100.
- Rotate-right burst: load 1100, i_steps=5, enable held high:
  - Expect 0110, 0011, 1001, 1100, 0110.
  - o_busy high 5 cycles; o_done pulses once after the 5th shift; final value 0110.
- Arithmetic: load 1000, right burst steps=2 -> 1100, 1110. Load 0101, left steps=1 -> 1010, o_serial_out=0.
- Pause and ignore: burst steps=3 with enable pattern 1,0,0,1,1 -> 3 shifts over 5 cycles, o_busy held throughout. i_start and i_shift_dir toggles mid-burst have no effect.
- Abort and boundaries:
  - i_load 1010 mid-burst -> 1010, o_busy=0, no o_done.
  - i_start with steps=0 -> o_done pulse, register unchanged.
  - Reset mid-burst -> 1100, o_busy=0, no o_done.
